// File: rtl/tetris_piece_ctrl.sv
// Falling-piece motion controller: gravity, auto-repeat moves, rotate requests,
// lock delay and the lock/spawn handshake with the board store.
module tetris_piece_ctrl #(
    parameter int unsigned BLOCK     = 20,
    parameter int unsigned BOARD_W   = 480,
    parameter int unsigned BOARD_H   = 480,
    parameter int unsigned SPAWN_X   = 280,
    parameter int unsigned LVL_W     = 4,
    parameter int unsigned GRAV_BASE = 12500000,
    parameter int unsigned GRAV_STEP = 800000,
    parameter int unsigned GRAV_MIN  = 1000000,
    parameter int unsigned DAS_DELAY = 4500000,
    parameter int unsigned DAS_RATE  = 3000000,
    parameter int unsigned SOFT_STEP = 2,
    parameter int unsigned LOCK_CYC  = 6250000
) (
    input  logic             iVGA_CLK,
    input  logic             start_over,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_down,
    input  logic             btn_rot,
    input  logic [LVL_W-1:0] level,
    input  logic [2:0]       ext_left,
    input  logic [2:0]       ext_w,
    input  logic [2:0]       ext_h,
    input  logic             blk_left,
    input  logic             blk_right,
    input  logic             blk_down,
    input  logic             next_ready,
    output logic [9:0]       ref_x,
    output logic [9:0]       ref_y,
    output logic             rot_req,
    output logic             locked,
    output logic             game_over,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        ST_FALL       = 3'd0,
        ST_LOCK_DELAY = 3'd1,
        ST_LOCKED     = 3'd2,
        ST_SPAWN      = 3'd3,
        ST_GAME_OVER  = 3'd4
    } state_e;

    localparam int unsigned DAS_MAX = (DAS_DELAY > DAS_RATE) ? DAS_DELAY : DAS_RATE;
    localparam int unsigned DCW     = $clog2(DAS_MAX + 1);

    state_e         state_q, state_d;
    logic [9:0]     x_q, x_d, y_q, y_d;
    logic [31:0]    grav_q, grav_d, lock_q, lock_d;
    logic [3:0]     sync1_q, sync2_q, prev_q;
    logic [DCW-1:0] das_q [3];
    logic [DCW-1:0] das_d [3];
    logic [2:0]     rep_q, rep_d, pend_q, pend_d;
    logic           rot_q, rot_d, locked_q, locked_d;

    logic [3:0]     held, press;
    logic [2:0]     masked, hit, req, grant;
    logic           live, tick;
    logic [31:0]    lvl_prod, period;
    logic [9:0]     drop_px;
    logic           blocked_left, blocked_right, blocked_down;

    // Button bits: 0 left, 1 right, 2 down, 3 rotate (inputs are active-low).
    assign held   = ~sync2_q;
    assign press  = held & prev_q;
    assign live   = (state_q == ST_FALL) || (state_q == ST_LOCK_DELAY);
    assign masked = {held[0] | held[1], held[0], 1'b0};

    always_comb begin
        lvl_prod = 32'(level) * 32'(GRAV_STEP);
        if (lvl_prod >= GRAV_BASE)
            period = GRAV_MIN;
        else if ((GRAV_BASE - lvl_prod) < GRAV_MIN)
            period = GRAV_MIN;
        else
            period = GRAV_BASE - lvl_prod;
    end

    assign tick = live && (grav_q >= period - 32'd1);

    always_comb begin
        blocked_down  = blk_down  || ((32'(y_q) + 32'(ext_h) * BLOCK) >= BOARD_H);
        blocked_left  = blk_left  || (32'(x_q) < (32'(ext_left) + 32'd1) * BLOCK);
        blocked_right = blk_right || ((32'(x_q) + 32'(ext_w) * BLOCK) >= BOARD_W);
        // Largest soft-drop step that still fits above the floor.
        drop_px = '0;
        for (int unsigned k = 1; k <= SOFT_STEP; k++) begin
            if ((32'(y_q) + (32'(ext_h) + k) * BLOCK) <= BOARD_H)
                drop_px = 10'(k * BLOCK);
        end
    end

    always_comb begin
        hit    = '0;
        req    = '0;
        grant  = '0;
        rep_d  = rep_q;
        pend_d = pend_q;
        for (int unsigned i = 0; i < 3; i++) begin
            das_d[i] = das_q[i];
            hit[i]   = held[i] && !masked[i] && !press[i] &&
                       (das_q[i] >= (rep_q[i] ? DCW'(DAS_RATE) : DCW'(DAS_DELAY)));
            req[i]   = live && held[i] && (press[i] || pend_q[i] || hit[i]);
            grant[i] = req[i] && !masked[i] && !tick;
        end
        // A request that loses to gravity or priority stays pending; DAS timing is untouched.
        for (int unsigned i = 0; i < 3; i++) begin
            if (!held[i] || !live) begin
                das_d[i] = '0;
                rep_d[i] = 1'b0;
                pend_d[i] = 1'b0;
            end else if (press[i]) begin
                das_d[i] = DCW'(1);
                rep_d[i] = 1'b0;
                pend_d[i] = !grant[i];
            end else if (masked[i]) begin
                pend_d[i] = pend_q[i];
            end else if (hit[i]) begin
                das_d[i] = DCW'(1);
                rep_d[i] = 1'b1;
                pend_d[i] = !grant[i];
            end else begin
                das_d[i] = das_q[i] + DCW'(1);
                pend_d[i] = pend_q[i] && !grant[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        lock_d   = lock_q;
        locked_d = 1'b0;
        grav_d   = (tick || !live) ? '0 : grav_q + 32'd1;
        rot_d    = live && press[3];
        if (live) begin
            if (grant[0] && !blocked_left)
                x_d = x_q - 10'(BLOCK);
            else if (grant[1] && !blocked_right)
                x_d = x_q + 10'(BLOCK);
            else if (grant[2] && !blocked_down)
                y_d = y_q + drop_px;
        end
        case (state_q)
            ST_FALL: begin
                if (tick) begin
                    if (blocked_down) begin
                        state_d = ST_LOCK_DELAY;
                        lock_d  = '0;
                    end else begin
                        y_d = y_q + 10'(BLOCK);
                    end
                end
            end
            ST_LOCK_DELAY: begin
                if (!blocked_down) begin
                    state_d = ST_FALL;
                end else if (lock_q >= LOCK_CYC - 1) begin
                    state_d  = ST_LOCKED;
                    locked_d = 1'b1;
                end else begin
                    lock_d = lock_q + 32'd1;
                end
            end
            ST_LOCKED: begin
                if (next_ready) begin
                    state_d = ST_SPAWN;
                    x_d     = 10'(SPAWN_X);
                    y_d     = '0;
                end
            end
            ST_SPAWN: begin
                x_d     = 10'(SPAWN_X);
                y_d     = '0;
                state_d = blk_down ? ST_GAME_OVER : ST_FALL;
            end
            ST_GAME_OVER: ;
            default: state_d = ST_FALL;
        endcase
    end

    always_ff @(posedge iVGA_CLK) begin
        if (!start_over) begin
            state_q  <= ST_FALL;
            x_q      <= 10'(SPAWN_X);
            y_q      <= '0;
            grav_q   <= '0;
            lock_q   <= '0;
            sync1_q  <= '1;
            sync2_q  <= '1;
            prev_q   <= '1;
            for (int unsigned i = 0; i < 3; i++) das_q[i] <= '0;
            rep_q    <= '0;
            pend_q   <= '0;
            rot_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            grav_q   <= grav_d;
            lock_q   <= lock_d;
            sync1_q  <= {btn_rot, btn_down, btn_right, btn_left};
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            for (int unsigned i = 0; i < 3; i++) das_q[i] <= das_d[i];
            rep_q    <= rep_d;
            pend_q   <= pend_d;
            rot_q    <= rot_d;
            locked_q <= locked_d;
        end
    end

    assign ref_x     = x_q;
    assign ref_y     = y_q;
    assign rot_req   = rot_q;
    assign locked    = locked_q;
    assign game_over = (state_q == ST_GAME_OVER);
    assign state     = state_q;

endmodule

// File: tb/tb_tetris_piece_ctrl.sv
// Directed bench for tetris_piece_ctrl with shortened timing parameters.
module tb_tetris_piece_ctrl;

    logic       clk = 1'b0;
    logic       start_over = 1'b0;
    logic       btn_left = 1'b1, btn_right = 1'b1, btn_down = 1'b1, btn_rot = 1'b1;
    logic [3:0] level = '0;
    logic [2:0] ext_left = 3'd0, ext_w = 3'd1, ext_h = 3'd1;
    logic       blk_left = 1'b0, blk_right = 1'b0, blk_down = 1'b0, next_ready = 1'b0;
    logic [9:0] ref_x, ref_y;
    logic       rot_req, locked, game_over;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;
    int t_now = 0;
    int rc;

    always #5 clk = ~clk;

    tetris_piece_ctrl #(
        .GRAV_BASE(100), .GRAV_STEP(10), .GRAV_MIN(20),
        .DAS_DELAY(16), .DAS_RATE(4), .LOCK_CYC(8)
    ) dut (
        .iVGA_CLK(clk), .start_over(start_over),
        .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down), .btn_rot(btn_rot),
        .level(level), .ext_left(ext_left), .ext_w(ext_w), .ext_h(ext_h),
        .blk_left(blk_left), .blk_right(blk_right), .blk_down(blk_down),
        .next_ready(next_ready),
        .ref_x(ref_x), .ref_y(ref_y), .rot_req(rot_req), .locked(locked),
        .game_over(game_over), .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step_to(input int t);
        while (t_now < t) begin
            @(negedge clk);
            t_now++;
        end
    endtask

    task automatic count_rot(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            t_now++;
            if (rot_req) c++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_x", ref_x, 280);
        chk("rst_y", ref_y, 0);
        chk("rst_state", state, 0);
        chk("rst_go", game_over, 0);
        chk("rst_lock", locked, 0);
        chk("rst_rot", rot_req, 0);

        // Left held: moves at +0, +16, +20, +24 ...
        start_over = 1'b1;
        btn_left   = 1'b0;
        t_now      = 0;
        step_to(2);  chk("das_pre", ref_x, 280);
        step_to(3);  chk("das_0", ref_x, 260);
        step_to(18); chk("das_wait", ref_x, 260);
        step_to(19); chk("das_16", ref_x, 240);
        step_to(23); chk("das_20", ref_x, 220);
        step_to(27); chk("das_24", ref_x, 200);
        step_to(40); btn_left = 1'b1;
        step_to(44); chk("das_end", ref_x, 140); chk("das_y", ref_y, 0);

        // Left wall boundary and board collision
        ext_left = 3'd6; btn_left = 1'b0;
        step_to(47); chk("wall_edge_ok", ref_x, 120); btn_left = 1'b1;
        step_to(50); btn_left = 1'b0;
        step_to(53); chk("wall_block", ref_x, 120); btn_left = 1'b1;
        step_to(56); ext_left = 3'd0; blk_left = 1'b1; btn_left = 1'b0;
        step_to(59); chk("blk_left", ref_x, 120); btn_left = 1'b1;
        step_to(62); blk_left = 1'b0;

        // Gravity periods: level 0 -> 100, level 15 -> 20 (clamped), level 3 -> 70
        step_to(99);  chk("grav0_pre", ref_y, 0);
        step_to(100); chk("grav0_t1", ref_y, 20);
        step_to(199); chk("grav0_pre2", ref_y, 20);
        step_to(200); chk("grav0_t2", ref_y, 40); level = 4'd15;
        step_to(219); chk("grav15_pre", ref_y, 40);
        step_to(220); chk("grav15_t1", ref_y, 60);
        step_to(240); chk("grav15_t2", ref_y, 80); level = 4'd3;
        step_to(309); chk("grav3_pre", ref_y, 80);
        step_to(310); chk("grav3_t1", ref_y, 100); level = 4'd15;

        // Fall to the floor and enter lock delay
        rc = 0;
        while (state != 3'd1 && rc < 500) begin
            @(negedge clk);
            rc++;
        end
        chk("lockdelay_entry", state, 1);
        chk("floor_y", ref_y, 460);
        t_now = 0;
        step_to(2); next_ready = 1'b1;
        step_to(7); chk("early_ready_ignored", state, 1); chk("lock_pre", locked, 0);
        next_ready = 1'b0;
        step_to(8);  chk("lock_pulse", locked, 1); chk("locked_state", state, 2);
        step_to(9);  chk("lock_pulse_end", locked, 0);
        step_to(13); chk("locked_hold", state, 2); next_ready = 1'b1;
        step_to(14); chk("spawn_state", state, 3); chk("spawn_x", ref_x, 280); chk("spawn_y", ref_y, 0);
        next_ready = 1'b0;
        step_to(15); chk("spawn_fall", state, 0);
        level = 4'd0;
        t_now = 0;

        // Right wall boundary with a wide piece
        ext_w = 3'd7; btn_right = 1'b0;
        step_to(3);  chk("right_1", ref_x, 300); btn_right = 1'b1;
        step_to(6);  btn_right = 1'b0;
        step_to(9);  chk("right_2", ref_x, 320); btn_right = 1'b1;
        step_to(12); btn_right = 1'b0;
        step_to(15); chk("right_edge_ok", ref_x, 340); btn_right = 1'b1;
        step_to(18); btn_right = 1'b0;
        step_to(21); chk("right_wall", ref_x, 340); btn_right = 1'b1; ext_w = 3'd1;

        // Rotation: one pulse per press, no repeat while held
        step_to(24); btn_rot = 1'b0;
        count_rot(20, rc); chk("rot_held_once", rc, 1);
        btn_rot = 1'b1;
        count_rot(4, rc);  chk("rot_release", rc, 0);
        btn_rot = 1'b0;
        count_rot(4, rc);  chk("rot_second", rc, 1);
        btn_rot = 1'b1;
        count_rot(4, rc);  chk("rot_idle", rc, 0);

        // Lock delay aborted when a right move clears the collision
        blk_down = 1'b1;
        step_to(99);  chk("ld_pre", state, 0);
        step_to(100); chk("ld_enter", state, 1); chk("ld_y", ref_y, 0); btn_right = 1'b0;
        step_to(103); chk("ld_move", ref_x, 360); btn_right = 1'b1; blk_down = 1'b0;
        step_to(104); chk("ld_abort", state, 0);
        step_to(110); chk("ld_abort_hold", state, 0); chk("ld_no_lock", locked, 0);

        // Gravity tick and left press in the same cycle
        step_to(197); btn_left = 1'b0;
        step_to(200); chk("coll_grav_y", ref_y, 20); chk("coll_x_hold", ref_x, 360);
        step_to(201); chk("coll_left_retry", ref_x, 340); btn_left = 1'b1;

        // Soft drop: two cells, auto-repeat, blk_down, floor limit
        step_to(204); btn_down = 1'b0;
        step_to(207); chk("soft_1", ref_y, 60); btn_down = 1'b1;
        step_to(210); btn_down = 1'b0;
        step_to(213); chk("soft_2", ref_y, 100);
        step_to(228); chk("soft_das_wait", ref_y, 100);
        step_to(229); chk("soft_das", ref_y, 140);
        step_to(245); chk("soft_rep", ref_y, 300); btn_down = 1'b1;
        step_to(250); chk("soft_stop", ref_y, 300);
        ext_h = 3'd7; blk_down = 1'b1; btn_down = 1'b0;
        step_to(253); chk("soft_blk", ref_y, 300); btn_down = 1'b1;
        step_to(256); blk_down = 1'b0; btn_down = 1'b0;
        step_to(259); chk("soft_full", ref_y, 340); btn_down = 1'b1;
        step_to(262); ext_h = 3'd6; btn_down = 1'b0;
        step_to(265); chk("soft_one_cell", ref_y, 360); btn_down = 1'b1;
        step_to(268); btn_down = 1'b0;
        step_to(271); chk("soft_floor", ref_y, 360); btn_down = 1'b1;

        // Lock on the floor; rotate ignored in LOCKED
        step_to(299); chk("lock2_pre", state, 0);
        step_to(300); chk("lock2_enter", state, 1);
        step_to(306); btn_rot = 1'b0;
        step_to(307); chk("lock2_nopulse", locked, 0); chk("rot_ld_none", rot_req, 0);
        step_to(308); chk("lock2_pulse", locked, 1); chk("lock2_state", state, 2);
        step_to(309); chk("lock2_end", locked, 0); chk("rot_locked_0", rot_req, 0);
        count_rot(5, rc); chk("rot_locked", rc, 0);

        // Spawn into a blocked board -> game over; reset clears it
        btn_rot = 1'b1; blk_down = 1'b1; next_ready = 1'b1;
        step_to(315); chk("go_spawn", state, 3); chk("go_spawn_x", ref_x, 280); chk("go_spawn_y", ref_y, 0);
        chk("go_not_yet", game_over, 0);
        next_ready = 1'b0; btn_left = 1'b0;
        step_to(316); chk("go_state", state, 4); chk("go_flag", game_over, 1);
        step_to(321); chk("go_frozen_x", ref_x, 280); chk("go_frozen_y", ref_y, 0); chk("go_sticky", game_over, 1);
        btn_left = 1'b1; start_over = 1'b0;
        step_to(322); chk("rst2_go", game_over, 0); chk("rst2_state", state, 0);
        chk("rst2_x", ref_x, 280); chk("rst2_y", ref_y, 0);
        start_over = 1'b1; blk_down = 1'b0;
        step_to(330);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tetris_piece_ctrl.md
Name: tetris_piece_ctrl

Overview:
- Parametrised falling-piece motion controller for the VGA Tetris datapath.
- Owns the active piece's reference position (ref_x, ref_y, pixels): gravity with level-scaled speed, auto-repeat left/right/soft-drop, rotation request pulses, lock-delay, and a lock/spawn handshake with the board store.
- Piece extents and collision flags come from the shape ROM and the board store. This block does no shape decoding.

Parameters:
- BLOCK, 20, cell size in pixels
- BOARD_W, 480, playfield width in pixels
- BOARD_H, 480, playfield height in pixels
- SPAWN_X, 280, ref_x at spawn
- LVL_W, 4, width of level input
- GRAV_BASE, 12500000, gravity period (cycles) at level 0
- GRAV_STEP, 800000, period reduction per level
- GRAV_MIN, 1000000, gravity period floor
- DAS_DELAY, 4500000, held-button delay before auto-repeat (cycles)
- DAS_RATE, 3000000, auto-repeat period (cycles)
- SOFT_STEP, 2, cells moved per soft-drop step
- LOCK_CYC, 6250000, lock-delay length (cycles)

Ports:
- iVGA_CLK  in  1  system clock
- start_over  in  1  synchronous active-low reset
- btn_left, btn_right, btn_down, btn_rot  in  1 each  buttons, active-low
- level  in  LVL_W  current speed level
- ext_left  in  3  occupied cells left of ref column
- ext_w  in  3  occupied cells from ref column rightward (≥1)
- ext_h  in  3  occupied cells from ref row downward (≥1)
- blk_left, blk_right, blk_down  in  1 each  board store: the one-cell move in that direction would collide
- next_ready  in  1  board has merged the piece and loaded the next shape
- ref_x, ref_y  out  10 each  piece reference position, pixels
- rot_req  out  1  one-cycle rotate request to the shape selector
- locked  out  1  one-cycle pulse when the piece locks
- game_over  out  1  sticky game-over flag
- state  out  3  FSM state, for debug

Behaviour:
- Reset (start_over=0 at a clock edge): ref_x=SPAWN_X, ref_y=0, rot_req=0, locked=0, game_over=0, state=FALL; all counters cleared. Reset mid-lock or mid-handshake aborts to this state.
- Gravity period P = max(GRAV_BASE − level·GRAV_STEP, GRAV_MIN), computed in 32 bits with no underflow (clamp when level·GRAV_STEP ≥ GRAV_BASE). Gravity counter resets on each tick, on spawn and on reset.
- Geometry (width rules):
  - floor: ref_y + ext_h·BLOCK ≥ BOARD_H.
  - left wall: ref_x < (ext_left+1)·BLOCK.
  - right wall: ref_x + ext_w·BLOCK ≥ BOARD_W.
  - Effective blocked_dir = blk_dir OR wall/floor condition.
- Buttons are sampled and 2-flop synchronised.
  - A falling edge acts once immediately.
  - While held: a repeat after DAS_DELAY cycles, then every DAS_RATE cycles.
  - Priority left > right > down; only one move per cycle. A lower-priority held button's repeat counter holds while it is masked.
  - Moving a piece never changes its shape.
- Left/right: ±BLOCK unless blocked.
- Soft drop: moves down min(SOFT_STEP, cells to floor) cells, but only if blk_down=0. The board store flags one-cell collisions only, so with blk_down=0 the step is limited by the floor only.
- Gravity vs move in the same cycle: gravity wins; the move is retried next cycle without resetting DAS.
- btn_rot: falling edge → rot_req pulse (1 cycle), only in FALL/LOCK_DELAY; no auto-repeat.
- FSM states:
  - FALL(0): a gravity tick with blocked_down=0 does ref_y += BLOCK. A tick with blocked_down=1 goes to LOCK_DELAY and clears the lock counter.
  - LOCK_DELAY(1): moves and rotation stay live. If blocked_down drops to 0, return to FALL. After LOCK_CYC cycles, go to LOCKED.
  - LOCKED(2): locked=1 for exactly the entry cycle; inputs ignored. Wait for next_ready=1, then go to SPAWN.
  - SPAWN(3): ref_x=SPAWN_X, ref_y=0. The next cycle evaluates blk_down: if 1, go to GAME_OVER, else FALL.
  - GAME_OVER(4): game_over=1, position frozen; only reset exits.
- next_ready asserted before LOCKED is ignored; the handshake is level-sensitive only in LOCKED.

Test Plan (bench overrides GRAV_BASE=100, GRAV_STEP=10, GRAV_MIN=20, DAS_DELAY=16, DAS_RATE=4, LOCK_CYC=8, other params default):
- Reset, level=0, no buttons, ext_h=1 → ref_y steps 0,20,40… every 100 cycles; reaches 460, LOCK_DELAY, locked pulse 8 cycles later; state holds LOCKED until next_ready.
- level=15 → period clamps to 20 cycles (no underflow); level=3 → 70 cycles.
- btn_left held 40 cycles from ref_x=280, ext_left=0 → moves at +0, +16, +20, +24 … (ref_x 260, 240, …); ref_x=20 with ext_left=1 → no move.
- In LOCK_DELAY, drop blk_down via a right move → returns to FALL, locked not pulsed; gravity tick colliding with a left press → gravity applied, left applied next cycle.
- btn_rot pressed twice → two single-cycle rot_req pulses; held → no repeat; during LOCKED → none.
- locked, then next_ready with blk_down=1 → ref=(280,0), game_over=1; start_over=0 → game_over=0, state=FALL.
